// File: rtl/dpsk_sym_decoder.sv
// dpsk_sym_decoder: slices the sign of a sample once per symbol, decodes it
// as absolute PSK or differential PSK, and assembles the bits into bytes
// with the most significant bit first.
module dpsk_sym_decoder #(
  parameter int DW    = 8,
  parameter int SPS   = 64,
  parameter int PHASE = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          sym_sync,
  input  logic          mode,
  input  logic [DW-1:0] data,
  output logic          bit_out,
  output logic          bit_valid,
  output logic [DW-1:0] dm_out,
  output logic [7:0]    byte_out,
  output logic          byte_valid
);

  localparam int             CW      = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SPS - 1);
  localparam logic [CW-1:0]  CNT_DEC = CW'(PHASE);

  logic [CW-1:0] r_cnt;
  logic          r_prev_s;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_bit;
  logic          r_bit_valid;
  logic [7:0]    r_byte;
  logic          r_byte_valid;

  logic          w_dec;
  logic          w_s;
  logic          w_bit;
  logic [7:0]    w_shift_next;
  logic          w_unused;

  // Only the sign bit carries decision information; the low bits are dropped.
  assign w_unused = ^data[DW-2:0];

  // A realign pulse always suppresses the decision on that edge.
  assign w_dec        = en & ~sym_sync & (r_cnt == CNT_DEC);
  assign w_s          = data[DW-1];
  assign w_bit        = mode ? (w_s ^ r_prev_s) : ~w_s;
  assign w_shift_next = {r_shift[6:0], w_bit};

  // Symbol counter: realign has priority, otherwise advance and wrap on enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (sym_sync) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
    end
  end

  // Bit decision: remembers the last symbol sign for differential decoding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_s    <= 1'b0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_bit_valid <= w_dec;
      if (w_dec) begin
        r_prev_s <= w_s;
        r_bit    <= w_bit;
      end
    end
  end

  // Byte framing: shift decided bits in MSB first, publish every eighth one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (sym_sync) begin
        r_bit_cnt <= 3'd0;
      end else if (w_dec) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte       <= w_shift_next;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

  assign bit_out    = r_bit;
  assign bit_valid  = r_bit_valid;
  assign dm_out     = {DW{r_bit}};
  assign byte_out   = r_byte;
  assign byte_valid = r_byte_valid;

endmodule

// File: tb/tb_dpsk_sym_decoder.sv
// tb_dpsk_sym_decoder: directed stimulus with a scoreboard; the stimulus
// queues expected bits (value, byte flag, cycle) and bytes, and a monitor
// compares them whenever the decoder presents an output pulse.
module tb_dpsk_sym_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sym_sync = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] data = 8'h00;
  logic       bit_out;
  logic       bit_valid;
  logic [7:0] dm_out;
  logic [7:0] byte_out;
  logic       byte_valid;

  typedef struct {
    logic b;
    logic bv;
    int   cyc;
  } exp_t;

  exp_t       bit_q[$];
  logic [7:0] byte_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;

  dpsk_sym_decoder #(.DW(8), .SPS(64), .PHASE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sym_sync   (sym_sync),
    .mode       (mode),
    .data       (data),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .dm_out     (dm_out),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every bit_valid pops one expected bit; every byte_valid pops one byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_bit_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = bit_q.pop_front();
          $display("[TB] bit cyc=%0d bit_out=%0d dm_out=%02h byte_valid=%0d",
                   cyc, bit_out, dm_out, byte_valid);
          chk("bit_out", 32'(bit_out), 32'(e.b));
          chk("dm_out", 32'(dm_out), 32'({8{e.b}}));
          chk("bit_cycle", 32'(cyc), 32'(e.cyc));
          chk("byte_valid_flag", 32'(byte_valid), 32'(e.bv));
        end
      end
      if (byte_valid) begin
        if (!bit_valid) chk("byte_valid_without_bit", 32'd1, 32'd0);
        if (byte_q.size() == 0) begin
          chk("unexpected_byte_valid", 32'd1, 32'd0);
        end else begin
          logic [7:0] eb;
          eb = byte_q.pop_front();
          $display("[TB] byte cyc=%0d byte_out=%02h", cyc, byte_out);
          chk("byte_out", 32'(byte_out), 32'(eb));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_dm_out"}, 32'(dm_out), 32'd0);
    chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
  endtask

  // Pulse reset from a negedge, check outputs clear at once, release later.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero(tag);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = cyc;
  endtask

  // One symbol: the decision edge sees cnt==32, i.e. edge base+33.
  task automatic send_symbol(input logic sign, input logic exp_b, input logic exp_bv,
                             input int stall_at);
    exp_t e;
    data = {sign, 7'($urandom_range(0, 127))};
    if (stall_at >= 0) begin
      repeat (base + stall_at - cyc) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b1;
      base += 10;
    end
    e.b   = exp_b;
    e.bv  = exp_bv;
    e.cyc = base + 33;
    bit_q.push_back(e);
    repeat (e.cyc - cyc) @(negedge clk);
    base += 64;
  endtask

  // Realign so that the pulse is sampled on the edge where cnt==at_cnt.
  task automatic do_sync(input int at_cnt);
    repeat (base + at_cnt - cyc) @(negedge clk);
    sym_sync = 1'b1;
    @(negedge clk);
    sym_sync = 1'b0;
    base = cyc;
  endtask

  initial begin
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    en    = 1'b1;
    reset = 1'b0;
    base  = cyc;

    // Absolute PSK: negative sample -> 0, positive sample -> 1.
    mode = 1'b0;
    data = 8'h80;
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);

    // Differential: signs 1,1,0,0,1 after a previous sign of 0 -> 1,0,1,0,1.
    mode = 1'b1;
    send_symbol(1'b1, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b0, 1'b0, 1'b0, -1);
    send_symbol(1'b1, 1'b1, 1'b0, -1);

    // Byte assembly: bits 1,0,1,1,0,0,1,0 -> 8'hB2 on the eighth bit.
    do_reset("reset_a");
    mode = 1'b0;
    byte_q.push_back(8'hB2);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b1, -1);

    // Realign mid-symbol: next decision 33 clocks after the sync edge.
    do_sync(20);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    // Realign on the decision edge: that symbol yields no bit.
    data = 8'h80;
    do_sync(32);
    chk("sync32_no_bit_valid", 32'(bit_valid), 32'd0);
    send_symbol(1'b1, 1'b0, 1'b0, -1);

    // Enable stall of 10 cycles from cnt 30 delays the decision by 10.
    send_symbol(1'b0, 1'b1, 1'b0, 30);

    // Three more bits -> five bits into the byte, last bit_out=1.
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);

    // Reset mid-symbol and mid-byte; a byte needs 8 fresh bits: 0,1,0,1,1,1,0,0 -> 8'h5C.
    repeat (10) @(negedge clk);
    do_reset("reset_mid");
    byte_q.push_back(8'h5C);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b0, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b1, -1);

    // Differential after reset compares against a cleared previous sign.
    do_reset("reset_b");
    mode = 1'b1;
    send_symbol(1'b1, 1'b1, 1'b0, -1);
    send_symbol(1'b1, 1'b0, 1'b0, -1);

    repeat (40) @(negedge clk);
    chk("pending_bits", 32'(bit_q.size()), 32'd0);
    chk("pending_bytes", 32'(byte_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
